// File: rtl/shift_register_driver_if.sv
// Frame request/serial output bundle for the shift-register chain driver.
interface shift_register_driver_if #(
    parameter int unsigned CHAIN_BITS = 16
);
    logic [CHAIN_BITS-1:0] data_in;
    logic                  data_valid;
    logic                  refresh;
    logic                  data_ready;
    logic                  ser_data;
    logic                  shift_clk;
    logic                  latch_clk;
    logic                  done;

    // Requester side: presents frames, observes chain signals.
    modport master (
        output data_in, data_valid, refresh,
        input  data_ready, ser_data, shift_clk, latch_clk, done
    );

    // Driver side.
    modport slave (
        input  data_in, data_valid, refresh,
        output data_ready, ser_data, shift_clk, latch_clk, done
    );
endinterface

// File: rtl/shift_register_driver.sv
// Serialises a frame into an external daisy-chained shift-register chain, then
// pulses the storage latch. All outputs come straight from flops.
module shift_register_driver #(
    parameter int unsigned CHAIN_BITS = 16,
    parameter int unsigned CLK_DIV    = 8,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    shift_register_driver_if.slave bus
);
    localparam int unsigned BitW = $clog2(CHAIN_BITS + 1);
    localparam int unsigned DivW = $clog2(CLK_DIV + 1);

    localparam logic [BitW-1:0] BitsInit = BitW'(CHAIN_BITS);
    localparam logic [BitW-1:0] BitOne   = BitW'(1);
    localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivOne   = DivW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StLatch,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [DivW-1:0]       div_q, div_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [CHAIN_BITS-1:0] shift_q, shift_d;
    logic [CHAIN_BITS-1:0] held_q, held_d;

    logic data_ready_q, data_ready_d;
    logic shift_clk_q, shift_clk_d;
    logic latch_clk_q, latch_clk_d;
    logic done_q, done_d;

    // State, datapath and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            div_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            held_q       <= '0;
            data_ready_q <= 1'b0;
            shift_clk_q  <= 1'b0;
            latch_clk_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            held_q       <= held_d;
            data_ready_q <= data_ready_d;
            shift_clk_q  <= shift_clk_d;
            latch_clk_q  <= latch_clk_d;
            done_q       <= done_d;
        end
    end

    // Next-state and datapath: accept/refresh in idle, pace half-periods, count bits.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        held_d  = held_q;
        case (state_q)
            StIdle: begin
                div_d = '0;
                // Gate on the registered ready so nothing is taken in the
                // cycle right after reset, when data_ready is still low.
                if (data_ready_q && bus.data_valid) begin
                    shift_d = bus.data_in;
                    held_d  = bus.data_in;
                    bit_d   = BitsInit;
                    state_d = StShiftLo;
                end else if (data_ready_q && bus.refresh) begin
                    shift_d = held_q;
                    bit_d   = BitsInit;
                    state_d = StShiftLo;
                end
            end
            StShiftLo: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    state_d = StShiftHi;
                end else begin
                    div_d = div_q + DivOne;
                end
            end
            StShiftHi: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    bit_d   = bit_q - BitOne;
                    // Zeros fill from the far end, so the line idles low.
                    shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    state_d = (bit_q == BitOne) ? StLatch : StShiftLo;
                end else begin
                    div_d = div_q + DivOne;
                end
            end
            StLatch: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    state_d = StDone;
                end else begin
                    div_d = div_q + DivOne;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode of the next state, registered above so outputs track the state.
    always_comb begin
        data_ready_d = 1'b0;
        shift_clk_d  = 1'b0;
        latch_clk_d  = 1'b0;
        done_d       = 1'b0;
        case (state_d)
            StIdle:    data_ready_d = 1'b1;
            StShiftHi: shift_clk_d  = 1'b1;
            StLatch:   latch_clk_d  = 1'b1;
            StDone:    done_d       = 1'b1;
            default:   ;
        endcase
    end

    assign bus.data_ready = data_ready_q;
    assign bus.shift_clk  = shift_clk_q;
    assign bus.latch_clk  = latch_clk_q;
    assign bus.done       = done_q;
    assign bus.ser_data   = MSB_FIRST ? shift_q[CHAIN_BITS-1] : shift_q[0];
endmodule

// File: tb/tb_shift_register_driver.sv
// Drives three driver instances (8b/div2 MSB-first, 8b/div2 LSB-first,
// 1b/div1) from shared stimulus and checks each against a timing model.
module tb_shift_register_driver;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d_in;
    logic       v_in;
    logic       rf_in;

    always #5 clk = ~clk;

    shift_register_driver_if #(.CHAIN_BITS(8)) b0 ();
    shift_register_driver_if #(.CHAIN_BITS(8)) b1 ();
    shift_register_driver_if #(.CHAIN_BITS(1)) b2 ();

    assign b0.data_in = d_in;
    assign b1.data_in = d_in;
    assign b2.data_in = d_in[0];
    assign b0.data_valid = v_in;
    assign b1.data_valid = v_in;
    assign b2.data_valid = v_in;
    assign b0.refresh = rf_in;
    assign b1.refresh = rf_in;
    assign b2.refresh = rf_in;

    shift_register_driver #(.CHAIN_BITS(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );
    shift_register_driver #(.CHAIN_BITS(8), .CLK_DIV(2), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );
    shift_register_driver #(.CHAIN_BITS(1), .CLK_DIV(1), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .reset(reset), .bus(b2)
    );

    logic [2:0] rdy, ser, sck, lck, dn;
    assign rdy = {b2.data_ready, b1.data_ready, b0.data_ready};
    assign ser = {b2.ser_data, b1.ser_data, b0.ser_data};
    assign sck = {b2.shift_clk, b1.shift_clk, b0.shift_clk};
    assign lck = {b2.latch_clk, b1.latch_clk, b0.latch_clk};
    assign dn  = {b2.done, b1.done, b0.done};

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %0d, expected %0d", nm, inst, cyc, act, exp);
        end
    endtask

    // Model: per instance, a frame occupies cycles t = 0 .. 2*N*D+D after the
    // accepting edge: N bit slots of 2*D (low half then high half), D latch
    // cycles, one done cycle.
    int         nb  [3] = '{8, 8, 1};
    int         dvs [3] = '{2, 2, 1};
    bit         msb [3] = '{1'b1, 1'b0, 1'b1};
    bit         busy [3];
    int         t [3];
    logic [7:0] frame [3];
    logic [7:0] held [3];
    bit         rst_flag [3];
    bit         model_ok = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) model_ok <= 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                busy[i]     <= 1'b0;
                held[i]     <= 8'h00;
                rst_flag[i] <= 1'b1;
            end else if (!busy[i]) begin
                rst_flag[i] <= 1'b0;
                if (!rst_flag[i] && v_in) begin
                    frame[i] <= d_in & ((nb[i] == 8) ? 8'hFF : 8'h01);
                    held[i]  <= d_in & ((nb[i] == 8) ? 8'hFF : 8'h01);
                    busy[i]  <= 1'b1;
                    t[i]     <= 0;
                end else if (!rst_flag[i] && rf_in) begin
                    frame[i] <= held[i];
                    busy[i]  <= 1'b1;
                    t[i]     <= 0;
                end
            end else if (t[i] == 2 * nb[i] * dvs[i] + dvs[i]) begin
                busy[i] <= 1'b0;
            end else begin
                t[i] <= t[i] + 1;
            end
        end
    end

    // Observation trackers, written only by the compare process.
    logic [7:0] cap [3];
    int rises [3];
    int lat_cnt [3];
    int lat_run [3];
    int lat_w [3];
    int hi_run [3];
    int hi_w [3];
    int done_cnt [3];
    int done_cyc [3];
    logic [2:0] sck_p = '0;
    logic [2:0] lck_p = '0;

    logic e_rdy, e_sck, e_lck, e_dn, e_ser, ser_live;
    int   per, span, bi;

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 3; i++) begin
                e_rdy = 0; e_sck = 0; e_lck = 0; e_dn = 0; e_ser = 0; ser_live = 0;
                per  = 2 * dvs[i];
                span = per * nb[i];
                if (rst_flag[i]) begin
                    ser_live = 1;
                end else if (!busy[i]) begin
                    e_rdy = 1;
                end else if (t[i] < span) begin
                    e_sck = (t[i] % per) >= dvs[i];
                    bi = t[i] / per;
                    e_ser = msb[i] ? frame[i][nb[i] - 1 - bi] : frame[i][bi];
                    ser_live = 1;
                end else if (t[i] < span + dvs[i]) begin
                    e_lck = 1;
                end else begin
                    e_dn = 1;
                end
                chk("data_ready", i, rdy[i], e_rdy);
                chk("shift_clk", i, sck[i], e_sck);
                chk("latch_clk", i, lck[i], e_lck);
                chk("done", i, dn[i], e_dn);
                if (ser_live) chk("ser_data", i, ser[i], e_ser);

                if (sck[i] && !sck_p[i]) begin
                    rises[i]++;
                    cap[i] = {cap[i][6:0], ser[i]};
                end
                if (sck[i]) hi_run[i]++;
                else if (sck_p[i]) begin hi_w[i] = hi_run[i]; hi_run[i] = 0; end
                if (lck[i] && !lck_p[i]) lat_cnt[i]++;
                if (lck[i]) lat_run[i]++;
                else if (lck_p[i]) begin lat_w[i] = lat_run[i]; lat_run[i] = 0; end
                if (dn[i]) begin done_cnt[i]++; done_cyc[i] = cyc; end
            end
            sck_p = sck;
            lck_p = lck;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int c0, dc, r0, lc;

    task automatic wait_idle();
        for (int n = 0; n < 300 && !(rdy[0] && rdy[2]); n++) tick();
        chk("idle_reached", 0, rdy[0] & rdy[2], 1);
    endtask

    task automatic send(input bit v, input bit r, input logic [7:0] d);
        wait_idle();
        c0 = cyc;
        dc = done_cnt[0];
        r0 = rises[0];
        d_in = d; v_in = v; rf_in = r;
        tick();
        v_in = 0; rf_in = 0;
        d_in = 8'($urandom);
        for (int n = 0; n < 300 && done_cnt[0] == dc; n++) tick();
        chk("done_seen", 0, done_cnt[0] - dc, 1);
        chk("shift_edges", 0, rises[0] - r0, 8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1; v_in = 0; rf_in = 0; d_in = 8'h00;
        repeat (3) tick();
        chk("ready_in_reset", 0, rdy[0], 0);
        chk("ser_in_reset", 0, ser[0], 0);
        reset = 0;
        tick();
        chk("ready_after_reset", 0, rdy[0], 1);

        // Refresh before any frame sends zeros; data_in is not used.
        send(1'b0, 1'b1, 8'hFF);
        chk("refresh_zero", 0, cap[0], 8'h00);
        chk("refresh_latency", 0, done_cyc[0] - c0, 35);

        send(1'b1, 1'b0, 8'hA5);
        chk("a5_msb", 0, cap[0], 8'hA5);
        chk("a5_lsb", 1, cap[1], 8'hA5);
        chk("a5_bit", 2, cap[2][0], 1);
        chk("done_latency", 0, done_cyc[0] - c0, 35);
        chk("done_latency", 2, done_cyc[2] - c0, 4);
        chk("latch_width", 0, lat_w[0], 2);
        chk("latch_width", 2, lat_w[2], 1);
        chk("shift_hi_width", 2, hi_w[2], 1);
        chk("shift_hi_width", 0, hi_w[0], 2);

        send(1'b1, 1'b0, 8'h01);
        chk("x01_msb", 0, cap[0], 8'h01);
        chk("x01_lsb", 1, cap[1], 8'h80);

        send(1'b1, 1'b0, 8'h3C);
        chk("x3c_first", 0, cap[0], 8'h3C);
        send(1'b0, 1'b1, 8'h00);
        chk("x3c_refresh", 0, cap[0], 8'h3C);

        send(1'b1, 1'b1, 8'hFF);
        chk("valid_wins", 0, cap[0], 8'hFF);
        send(1'b0, 1'b1, 8'h00);
        chk("held_ff", 0, cap[0], 8'hFF);

        // data_valid pulses with 0x00 during SHIFT_HI must be ignored.
        wait_idle();
        r0 = rises[0];
        dc = done_cnt[0];
        d_in = 8'hFF; v_in = 1;
        tick();
        v_in = 0; d_in = 8'h00;
        for (int n = 0; n < 300 && done_cnt[0] == dc; n++) begin
            v_in = sck[0];
            tick();
        end
        v_in = 0;
        repeat (40) tick();
        chk("busy_edges", 0, rises[0] - r0, 8);
        chk("busy_frame", 0, cap[0], 8'hFF);
        chk("busy_one_done", 0, done_cnt[0] - dc, 1);

        // Reset after the 4th shift edge aborts without latch or done.
        wait_idle();
        r0 = rises[0];
        lc = lat_cnt[0];
        dc = done_cnt[0];
        d_in = 8'h5A; v_in = 1;
        tick();
        v_in = 0;
        for (int n = 0; n < 100 && rises[0] - r0 < 4; n++) tick();
        chk("abort_edges", 0, rises[0] - r0, 4);
        reset = 1;
        tick();
        chk("abort_sck", 0, sck[0], 0);
        chk("abort_lck", 0, lck[0], 0);
        chk("abort_ready", 0, rdy[0], 0);
        chk("abort_ser", 0, ser[0], 0);
        reset = 0;
        tick();
        chk("abort_ready_after", 0, rdy[0], 1);
        repeat (60) tick();
        chk("abort_no_latch", 0, lat_cnt[0] - lc, 0);
        chk("abort_no_done", 0, done_cnt[0] - dc, 0);

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            d_in  = 8'($urandom);
            v_in  = ($urandom_range(0, 3) == 0);
            rf_in = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 0; v_in = 0; rf_in = 0;
        repeat (50) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
